instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the instruction memory. It owns the program counter, drives the memory's 8-bit read address, and captures the returned 8-bit instruction into an instruction register. It presents that register to the decode/control stage over a valid/ready handshake. Jumps (opcode 2'b11) are resolved here, and a jump-to-self halts the machine.

Parameters:
ADDR_W, 8, PC and read-address width
INSTR_W, 8, instruction width; opcode is bits [7:6], jump target is bits [5:0]
MEM_DEPTH, 5, number of valid instruction words; any next PC >= MEM_DEPTH wraps to 0

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
Step  input  1  fetch enable (debounced single-step pulse, or tied high for free-run)
Read_Address  output  ADDR_W  to instruction memory; always equals PC
Instruction  input  INSTR_W  combinational memory data for Read_Address
IR  output  INSTR_W  registered instruction to decode
IR_Valid  output  1  IR holds an instruction not yet accepted
IR_Ready  input  1  decode accepts IR this cycle
PC_Out  output  ADDR_W  address of the instruction currently in IR
Instr_Count  output  8  number of issued instructions, saturating at 255
Halted  output  1  machine stopped on a jump-to-self

Behaviour:
- Reset (any state, any cycle): PC=0, IR=0, IR_Valid=0, PC_Out=0, Instr_Count=0, Halted=0, state=FETCH. An in-flight IR is discarded.
- States: FETCH, ISSUE, HALT.
- FETCH, Step=0: hold all state.
- FETCH, Step=1: at the edge, IR<=Instruction, PC_Out<=PC, IR_Valid<=1, PC<=next_pc, go to ISSUE.
- next_pc rules:
  - Opcode 2'b11: next_pc = {2'b00, IR-bits[5:0]}, an absolute target.
  - Any other opcode: next_pc = PC+1.
  - If the result is >= MEM_DEPTH, next_pc = 0. This applies to sequential and jump results alike.
- ISSUE: IR, PC_Out and PC are held stable while IR_Valid=1 and IR_Ready=0. Step is ignored.
- Handshake: a transfer occurs at the edge where IR_Valid=1 and IR_Ready=1. On that edge: IR_Valid<=0 and Instr_Count<=min(Instr_Count+1,255).
  - If IR is a jump whose target equals PC_Out, go to HALT and set Halted<=1.
  - Otherwise go to FETCH.
- IR_Ready high while IR_Valid=0 has no effect.
- Latency and throughput:
  - IR_Valid rises 1 cycle after a FETCH cycle with Step=1.
  - Minimum spacing is 2 cycles per instruction (FETCH, then ISSUE with Ready=1).
- HALT: IR_Valid=0 and Halted=1. Step and IR_Ready are ignored, PC is frozen, and the block leaves HALT only on reset.
- Jump instructions are still issued to decode (IR_Valid=1), so the decoder sees every instruction.
- Read_Address changes only on FETCH edges and on reset.

Test Plan:
Bench memory contents for scenarios 1-2 and 4-5: addr0=0x44, addr1=0x49, addr2=0x18, addr3=0x89, addr4=0xC3.
1. Reset, then Step=1 and IR_Ready=1 held -> IR sequence 0x44,0x49,0x18,0x89,0xC3,0x89,0xC3... with PC_Out 0,1,2,3,4,3,4. IR_Valid pulses every 2nd cycle. Instr_Count=7 after 7 handshakes. Halted stays 0.
2. Step=1, IR_Ready=0 for 6 cycles after the first fetch -> IR=0x44, IR_Valid=1, Read_Address=1, all held constant. Raising IR_Ready gives exactly one handshake, and IR=0x49 appears 2 cycles later.
3. Memory with addr2=0xC2 (jump to self), free-run -> issues 0x44, 0x49, 0xC2. Halted=1 the cycle after the 0xC2 handshake. IR_Valid stays 0 and Instr_Count=3 for 20 further cycles with Step=1.
4. Memory with addr4=0x00 (non-jump) and MEM_DEPTH=5 -> after PC_Out=4, the next IR is 0x44 with PC_Out=0 (wrap). Also, a jump with target 0x3F gives next PC=0.
5. Step pulsed 1 cycle every 10 cycles, IR_Ready=1 -> exactly one instruction is issued per pulse, and PC advances by one per pulse.
6. reset asserted for 1 cycle while in ISSUE with IR_Valid=1 and PC=3 -> the next cycle shows IR=0, IR_Valid=0, Read_Address=0, Instr_Count=0, and fetching restarts at 0x44.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage sitting directly in front of the instruction memory. It owns the
// program counter, drives the memory read address, and latches the returned
// instruction into an instruction register (IR). That register is offered to
// decode over a valid/ready handshake. Jumps (opcode 2'b11) are resolved here.
// A jump whose target is its own address halts the machine until reset.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   Step         fetch enable (single-step pulse, or tied high for free-run)
//   Read_Address instruction memory read address, always equal to the PC
//   Instruction  combinational memory data for Read_Address
//   IR           registered instruction presented to decode
//   IR_Valid     IR holds an instruction that decode has not yet accepted
//   IR_Ready     decode accepts IR this cycle
//   PC_Out       address of the instruction currently held in IR
//   Instr_Count  number of issued instructions, saturating at 255
//   Halted       machine stopped on a jump-to-self
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int ADDR_W    = 8,
    parameter int INSTR_W   = 8,
    parameter int MEM_DEPTH = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Step,
    output logic [ADDR_W-1:0]  Read_Address,
    input  logic [INSTR_W-1:0] Instruction,
    output logic [INSTR_W-1:0] IR,
    output logic               IR_Valid,
    input  logic               IR_Ready,
    output logic [ADDR_W-1:0]  PC_Out,
    output logic [7:0]         Instr_Count,
    output logic               Halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [1:0] OP_JUMP = 2'b11;

    state_t             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic               irValid_q;
    logic [ADDR_W-1:0]  pcOut_q;
    logic [7:0]         instrCount_q;
    logic               halted_q;

    logic [ADDR_W-1:0]  fetchTarget;
    logic [ADDR_W-1:0]  seqPc;
    logic [ADDR_W-1:0]  rawNextPc;
    logic [ADDR_W-1:0]  nextPc;
    logic               fetchIsJump;
    logic [ADDR_W-1:0]  irTarget;
    logic               irIsSelfJump;
    logic [7:0]         countInc;

    // Next-PC selection for the instruction being fetched this cycle. Both the
    // sequential and the jump result are folded back to 0 when they fall
    // outside the populated part of memory.
    always_comb begin
        fetchIsJump = (Instruction[INSTR_W-1 -: 2] == OP_JUMP);
        fetchTarget = ADDR_W'(Instruction[5:0]);
        seqPc       = pc_q + ADDR_W'(1);
        rawNextPc   = fetchIsJump ? fetchTarget : seqPc;
        nextPc      = (rawNextPc >= ADDR_W'(MEM_DEPTH)) ? '0 : rawNextPc;
    end

    // Halt detection uses the raw 6-bit target of the issued jump, compared
    // against the address the jump itself was fetched from.
    always_comb begin
        irTarget     = ADDR_W'(ir_q[5:0]);
        irIsSelfJump = (ir_q[INSTR_W-1 -: 2] == OP_JUMP) && (irTarget == pcOut_q);
        countInc     = (instrCount_q == 8'hFF) ? instrCount_q : instrCount_q + 8'd1;
    end

    // Fetch/issue/halt sequencer. ISSUE is only ever entered with IR valid, so
    // IR_Ready alone decides the handshake there. HALT is left only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= '0;
            ir_q         <= '0;
            irValid_q    <= 1'b0;
            pcOut_q      <= '0;
            instrCount_q <= 8'd0;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (Step) begin
                        ir_q      <= Instruction;
                        pcOut_q   <= pc_q;
                        irValid_q <= 1'b1;
                        pc_q      <= nextPc;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (IR_Ready) begin
                        irValid_q    <= 1'b0;
                        instrCount_q <= countInc;
                        if (irIsSelfJump) begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end else begin
                            state_q  <= FETCH;
                        end
                    end
                end
                HALT: begin
                    irValid_q <= 1'b0;
                    halted_q  <= 1'b1;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign Read_Address = pc_q;
    assign IR           = ir_q;
    assign IR_Valid     = irValid_q;
    assign PC_Out       = pcOut_q;
    assign Instr_Count  = instrCount_q;
    assign Halted       = halted_q;

endmodule
